// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and helpers for the gate1 IJTAG/functional data mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic {STABLE, HOLD} state_e;

  localparam int unsigned SettleCntW = 8;

  // Out-of-range selects fall back to the functional path (0).
  function automatic int unsigned sel_decode(input int unsigned sel, input int unsigned num_ch);
    return (sel > num_ch) ? 0 : sel;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_settle_ctrl.sv
// Source-switch sequencer: freezes the mux for a settle window before committing a new select.
module firebird7_in_gate1_tessent_data_mux_settle_ctrl
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SEL_W         = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic [SEL_W-1:0] i_eff_sel,
  output logic [SEL_W-1:0] o_active_sel,
  output logic             o_switching,
  output logic             o_load_en,
  output logic [SEL_W-1:0] o_load_sel
);

  localparam logic [SettleCntW-1:0] SettleLoad =
      (SETTLE_CYCLES > 0) ? SettleCntW'(SETTLE_CYCLES - 1) : '0;

  state_e                r_state, w_state_d;
  logic [SEL_W-1:0]      r_active_sel, w_active_sel_d;
  logic [SEL_W-1:0]      r_target, w_target_d;
  logic [SettleCntW-1:0] r_cnt, w_cnt_d;

  always_comb begin
    w_state_d      = r_state;
    w_active_sel_d = r_active_sel;
    w_target_d     = r_target;
    w_cnt_d        = r_cnt;
    o_load_en      = 1'b0;
    case (r_state)
      STABLE: begin
        o_load_en = 1'b1;
        if (i_eff_sel != r_active_sel) begin
          if (SETTLE_CYCLES == 0) begin
            w_active_sel_d = i_eff_sel;
          end else begin
            o_load_en  = 1'b0;
            w_state_d  = HOLD;
            w_cnt_d    = SettleLoad;
            w_target_d = i_eff_sel;
          end
        end
      end
      HOLD: begin
        // Returning to the current source cancels the switch outright.
        if (i_eff_sel == r_active_sel) begin
          w_state_d = STABLE;
        end else if (i_eff_sel != r_target) begin
          w_target_d = i_eff_sel;
          w_cnt_d    = SettleLoad;
        end else if (r_cnt == '0) begin
          w_active_sel_d = r_target;
          w_state_d      = STABLE;
          o_load_en      = 1'b1;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = STABLE;
    endcase
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_state      <= STABLE;
      r_active_sel <= '0;
      r_target     <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_d;
      r_active_sel <= w_active_sel_d;
      r_target     <= w_target_d;
      r_cnt        <= w_cnt_d;
    end
  end

  assign o_active_sel = r_active_sel;
  assign o_switching  = (r_state == HOLD);
  assign o_load_sel   = w_active_sel_d;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// Registered glitch-free mux between functional data and NUM_CH IJTAG sources.
// Optional TDR readback capture register enabled by TESSENT_DATA_MUX_CAPTURE_EN.
module firebird7_in_gate1_tessent_data_mux_sync
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned SEL_W         = $clog2(NUM_CH + 1)
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
  input  logic                    ijtag_capture,
  output logic [WIDTH-1:0]        capture_data,
`endif
  input  logic [SEL_W-1:0]        ijtag_select,
  input  logic [WIDTH-1:0]        functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        active_sel,
  output logic                    switching,
  output logic                    sel_err
);

  logic [SEL_W-1:0] w_eff_sel, w_load_sel;
  logic             w_load_en, w_sel_oor;
  logic [WIDTH-1:0] w_src [NUM_CH+1];
  logic [WIDTH-1:0] r_data;
  logic             r_sel_err;

  always_comb begin
    w_sel_oor = (32'(ijtag_select) > NUM_CH);
    w_eff_sel = SEL_W'(sel_decode(32'(ijtag_select), NUM_CH));
  end

  always_comb begin
    w_src[0] = functional_data_in;
    for (int c = 0; c < NUM_CH; c++) begin
      w_src[c+1] = ijtag_data_in[c*WIDTH +: WIDTH];
    end
  end

  firebird7_in_gate1_tessent_data_mux_settle_ctrl #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .SEL_W        (SEL_W)
  ) u_settle_ctrl (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .i_eff_sel   (w_eff_sel),
    .o_active_sel(active_sel),
    .o_switching (switching),
    .o_load_en   (w_load_en),
    .o_load_sel  (w_load_sel)
  );

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_data    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_sel_oor;
      if (w_load_en) begin
        r_data <= w_src[w_load_sel];
      end
    end
  end

  assign data_out = r_data;
  assign sel_err  = r_sel_err;

`ifdef TESSENT_DATA_MUX_CAPTURE_EN
  logic [WIDTH-1:0] r_capture;

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_capture <= '0;
    end else if (ijtag_capture) begin
      r_capture <= functional_data_in;
    end
  end

  assign capture_data = r_capture;
`else
  // Readback capture is compiled out; no extra state in this build.
`endif

endmodule
